multicycle_control: RTL
=======================

# multicycle_control

Main control FSM for the multi-cycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select, including the 3-bit ALUOp consumed by the ALU control unit. It also takes back the jump-register flag and the memory ready handshake.

## Interface

Parameters:
- none

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  Instruction[31:26] from the instruction register
- jr  in  1  jump-register flag from the ALU control unit; valid when ALUOp=010
- mem_ready  in  1  memory completes the current read or write this cycle
- mem_read, mem_write  out  1  memory strobes
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write  out  1  instruction register load
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load when the ALU zero flag is set
- pc_source  out  2  PC mux select: 00=ALU, 01=ALUOut, 10=jump target, 11=register A
- alu_src_a  out  1  ALU A select: 0=PC, 1=register A
- alu_src_b  out  2  ALU B select: 00=B, 01=4, 10=sign-extended imm, 11=imm<<2
- alu_op  out  3  encoding: 000=add, 001=subtract, 010=R-type (use funct), 100=and, 101=or
- reg_write, reg_dst, mem_to_reg  out  1  register file controls
- illegal_op  out  1  sticky flag for an unsupported opcode; cleared only by reset
- state  out  4  current state, for debug

## Operation

- Outputs not listed for a state are 0.
- Outputs decode from the state register (Moore), except for the gated strobes noted in FETCH and EXEC.
- IDLE (reset state): all outputs 0. Goes to FETCH on the next edge.
- FETCH:
  - mem_read=1, alu_src_b=01, alu_op=000.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_b=11, alu_op=000. Next state by opcode:
  - 000000 → EXEC
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi), 001100 (andi), 001101 (ori) → IEXEC
  - any other opcode → FETCH and set illegal_op
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=000. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, mem_read=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: mem_to_reg=1, reg_write=1, reg_dst=0. Goes to FETCH.
- MEMWR: iord=1, mem_write=1. Holds until mem_ready=1, then goes to FETCH.
- EXEC:
  - alu_src_a=1, alu_src_b=00, alu_op=010, pc_source=11.
  - pc_write=jr.
  - Goes to FETCH if jr=1, else ALUWB.
- ALUWB: reg_dst=1, reg_write=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_op=001, pc_write_cond=1, pc_source=01. Goes to FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10. alu_op is 000 for addi, 100 for andi, 101 for ori; opcode is held stable by the IR. Goes to IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10. Goes to FETCH.
- Unused state encodings go to IDLE.

## Timing

- rst_n low asynchronously forces state=IDLE and illegal_op=0. All outputs are 0 while reset is asserted.
- First FETCH occurs one cycle after rst_n deasserts.
- Cycles per instruction with mem_ready tied to 1:
  - beq, j, jr: 3
  - R-type, sw, addi, andi, ori: 4
  - lw: 5
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Memory strobes and iord are held constant for the entire wait.
- ir_write and pc_write pulse for exactly one cycle per fetch, in the cycle where mem_ready=1.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- Reset asserted mid-wait or mid-instruction abandons the instruction. No further write strobe is issued after reset asserts.

## Test plan

- Reset: rst_n=0 during a FETCH wait → state=IDLE, all outputs 0, illegal_op=0. Release → IDLE, then FETCH with mem_read=1.
- R-type add, mem_ready=1, jr=0 → state sequence FETCH, DECODE, EXEC, ALUWB, FETCH. alu_op=010 in EXEC; reg_write=1 and reg_dst=1 in ALUWB only.
- lw with mem_ready low for 2 cycles in MEMRD → iord=1 and mem_read=1 held 3 cycles; then MEMWB with mem_to_reg=1; 7 cycles total.
- beq then j → BRANCH shows pc_write_cond=1, alu_op=001, pc_source=01; JUMP shows pc_write=1, pc_source=10; 3 cycles each.
- R-type with jr=1 → EXEC has pc_write=1 and pc_source=11, then returns to FETCH with no reg_write.
- ori then opcode 111111:
  - ori: IEXEC shows alu_op=101.
  - 111111: DECODE→FETCH, illegal_op sets and stays 1 until the next reset.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath. It steps each instruction
// through fetch, decode, execute, memory and write-back, and drives every datapath control.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       jr,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic [3:0] state
);

  // Memory handshake: mem_read/mem_write and iord stay asserted and constant
  // until the cycle in which mem_ready=1, which is the cycle the transfer
  // completes. mem_ready is not looked at in any other state.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    illegal_d     = illegal_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR load and PC+4 happen only in the cycle the fetch completes
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:                   state_d = S_EXEC;
          OP_LW, OP_SW:               state_d = S_MEMADR;
          OP_BEQ:                     state_d = S_BRANCH;
          OP_J:                       state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI:   state_d = S_IEXEC;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        pc_source = 2'b11;
        // jr is resolved by ALU control from funct; it redirects PC and skips write-back
        pc_write  = jr;
        state_d   = jr ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = S_FETCH;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_ANDI: alu_op = 3'b100;
          OP_ORI:  alu_op = 3'b101;
          default: alu_op = 3'b000;
        endcase
        state_d = S_IWB;
      end
      S_IWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule
